riot_display_keypad: RTL and testbench
======================================

// Module: riot_display_keypad
// PURPOSE
// Downstream consumer of the RRIOT I/O ports. Decodes the multiplexed digit scan on PBO[4:1]/PAO[6:0]
// into six latched 7-segment digits for the host. Injects host-requested key presses back into PAI
// as an emulated 3x7 keypad matrix. Sits between the mcs6530 port pins and the board/host front end.
// PARAMETERS
// SETTLE_CYCLES   4      consecutive stable phi2 cycles before a digit scan is latched
// TIMEOUT_CYCLES  65535  cycles without refresh before a latched digit blanks to 0
// HOLD_CYCLES     20000  cycles an injected key is held down
// RELEASE_CYCLES  20000  cycles of forced release after a press, before next key is accepted
// PORTS
// phi2        in   1   clock, all logic on posedge
// rst_n       in   1   reset, synchronous, active-low
// pao         in   8   RRIOT port A output data
// ddra        in   8   RRIOT port A direction (1 = output)
// pbo         in   8   RRIOT port B output data
// ddrb        in   8   RRIOT port B direction (1 = output)
// pai         out  8   port A input to RRIOT (keypad columns, active-low)
// key_valid   in   1   host key request
// key_code    in   5   {row[1:0], col[2:0]}; row 0..2, col 0..6
// key_ready   out  1   injector idle; request accepted on key_valid & key_ready
// key_err     out  1   1-cycle pulse: accepted code invalid (row==3 or col==7)
// digits      out  42  digit d segments at [7d+6:7d], bit0 = seg a
// disp_changed out 1   1-cycle pulse when any bit of digits changes
// BEHAVIOUR
// - Reset: digits=0, pai=8'hFF, key_ready=0 during reset then 1, key_err=0, disp_changed=0, FSM IDLE, counters 0.
// - Effective select sel = per bit ddrb[i+1] ? pbo[i+1] : 1 (undriven bits read high). Effective seg = per bit ddra[i] ? pao[i] : 0.
// - sel 4..9 selects digit sel-4; sel 0..2 selects keypad row sel; other values select nothing.
// - Scan capture: settle counter increments while {sel,seg} equals previous cycle value and sel is a digit; any change clears it.
// - When counter reaches SETTLE_CYCLES-1: digit[sel-4] <= seg (registered, 1 cycle later), that digit's timeout counter cleared.
// - Counter saturates; a stable scan latches once per stable interval.
// - seg==0 also latches (explicit blank).
// - Timeout: per-digit counter increments every cycle, saturates; at TIMEOUT_CYCLES digit <= 0.
// - Latch wins over timeout in the same cycle.
// - disp_changed asserted the cycle after digits changes value; no pulse when rewrite/blank leaves value unchanged.
// - Key FSM states: IDLE -> PRESS (HOLD_CYCLES) -> RELEASE (RELEASE_CYCLES) -> IDLE.
//   - key_ready = (state==IDLE) & rst_n.
//   - Invalid code accepted in IDLE pulses key_err next cycle and stays IDLE.
// - Column drive: in PRESS, pai[col]=0 iff sel==row; else 1. pai[7]=1 always. pai is registered: 1-cycle latency from sel change.
// - key_valid while not ready is ignored (no queueing).
// - Reset mid-press releases the key immediately: pai=FF on the next edge.
// STRUCTURE
// - Package riot_pkg: typedef key_code_t {logic [1:0] row; logic [2:0] col;}, DIGIT_SEL_BASE=4, NUM_DIGITS=6, NUM_COLS=7, NUM_ROWS=3.
// - Sub-module riot_key_injector: key FSM, hold/release counters, key_err.
// - Top holds scan capture, timeouts and pai mux.
// - Counter widths: $clog2(param+1).
// TESTING
// - Reset: assert rst_n=0 two cycles -> digits=0, pai=FF, key_ready=0 then 1 after release.
// - Scan: ddrb=1E, pbo=08 (digit 0), ddra=7F, pao=3F held 4 cycles -> digits[6:0]=3F, disp_changed one pulse.
// - Glitch: same scan but pao changes after 2 cycles -> no latch; held 4 more cycles -> latches new value.
// - Timeout (TIMEOUT_CYCLES=100): latch digit 5 then stop scanning -> digits[41:35]=0 at cycle 100, disp_changed pulse.
// - Key: key_code={2'd1,3'd3} accepted; pbo[4:1]=1 -> pai=F7 one cycle later; pbo[4:1]=0 -> pai=FF.
//   After HOLD+RELEASE, key_ready=1.
// - Invalid/reset: key_code=5'b00111 -> key_err pulse, key_ready stays 1.
//   Valid press then rst_n=0 mid-hold -> pai=FF next edge.

Source files
------------

// File: rtl/riot_pkg.sv
// Shared types and constants for the RRIOT display/keypad front end.
package riot_pkg;

    localparam int DIGIT_SEL_BASE = 4;
    localparam int NUM_DIGITS     = 6;
    localparam int NUM_COLS       = 7;
    localparam int NUM_ROWS       = 3;

    typedef struct packed {
        logic [1:0] row;
        logic [2:0] col;
    } key_code_t;

    typedef enum logic [1:0] {
        KEY_IDLE    = 2'd0,
        KEY_PRESS   = 2'd1,
        KEY_RELEASE = 2'd2
    } key_state_e;

    // Row 3 and column 7 do not exist on the 3x7 matrix.
    function automatic logic key_code_ok(input key_code_t c);
        return (c.row != 2'd3) && (c.col != 3'd7);
    endfunction

endpackage

// File: rtl/riot_key_injector.sv
// Key press emulation: holds an accepted key down, then forces a release
// gap before the next request can be taken.
module riot_key_injector
    import riot_pkg::*;
#(
    parameter int HOLD_CYCLES    = 20000,
    parameter int RELEASE_CYCLES = 20000
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       key_valid_i,
    input  logic [4:0] key_code_i,
    output logic       key_ready_o,
    output logic       key_err_o,
    output logic       press_o,
    output key_code_t  code_o
);

    localparam int MAXC = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    key_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    key_code_t       code_q, code_d;
    logic            err_q, err_d;
    key_code_t       req;

    assign req = key_code_i;

    // State, phase counter, latched code and error pulse registers.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    // Next state: accept in IDLE, time out PRESS then RELEASE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        code_d  = code_q;
        err_d   = 1'b0;
        case (state_q)
            KEY_IDLE: begin
                cnt_d = '0;
                if (key_valid_i) begin
                    if (key_code_ok(req)) begin
                        code_d  = req;
                        state_d = KEY_PRESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            KEY_PRESS: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = KEY_RELEASE;
                    cnt_d   = '0;
                end
            end
            KEY_RELEASE: begin
                if (cnt_q == CW'(RELEASE_CYCLES - 1)) begin
                    state_d = KEY_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = KEY_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_ready_o = (state_q == KEY_IDLE) & rst_n;
    assign key_err_o   = err_q;
    assign press_o     = (state_q == KEY_PRESS);
    assign code_o      = code_q;

endmodule

// File: rtl/riot_display_keypad.sv
// Decodes the RRIOT multiplexed digit scan into latched 7-segment digits
// and drives the emulated keypad columns back into port A.
module riot_display_keypad
    import riot_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int HOLD_CYCLES    = 20000,
    parameter int RELEASE_CYCLES = 20000
) (
    input  logic        phi2,
    input  logic        rst_n,
    input  logic [7:0]  pao,
    input  logic [7:0]  ddra,
    input  logic [7:0]  pbo,
    input  logic [7:0]  ddrb,
    output logic [7:0]  pai,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        key_ready,
    output logic        key_err,
    output logic [41:0] digits,
    output logic        disp_changed
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        sel_digit;
    logic [2:0]  sel_idx;
    logic        scan_match;

    logic [10:0]                        scan_q;
    logic [SCW-1:0]                     settle_q, settle_d;
    logic                               lat_vld_q, lat_vld_d;
    logic [2:0]                         lat_idx_q;
    logic [6:0]                         lat_seg_q;
    logic [NUM_DIGITS-1:0][6:0]         digits_q, digits_d;
    logic [NUM_DIGITS-1:0][TCW-1:0]     tmo_q, tmo_d;
    logic                               chg_q, disp_q;
    logic [7:0]                         pai_q, pai_d;

    logic      press;
    key_code_t code;
    logic      unused_pins;

    // Undriven select lines float high; undriven segment lines read as off.
    assign sel        = (pbo[4:1] & ddrb[4:1]) | ~ddrb[4:1];
    assign seg        = pao[6:0] & ddra[6:0];
    assign sel_digit  = (sel >= 4'(DIGIT_SEL_BASE)) && (sel < 4'(DIGIT_SEL_BASE + NUM_DIGITS));
    assign sel_idx    = 3'(sel - 4'(DIGIT_SEL_BASE));
    assign scan_match = ({sel, seg} == scan_q);
    assign unused_pins = ^{pao[7], ddra[7], pbo[7:5], pbo[0], ddrb[7:5], ddrb[0]};

    riot_key_injector #(
        .HOLD_CYCLES    (HOLD_CYCLES),
        .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_inj (
        .phi2        (phi2),
        .rst_n       (rst_n),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .key_ready_o (key_ready),
        .key_err_o   (key_err),
        .press_o     (press),
        .code_o      (code)
    );

    // Settle counter saturates so a steady scan latches only once.
    always_comb begin
        settle_d = '0;
        if (scan_match && sel_digit)
            settle_d = (settle_q == SCW'(SETTLE_CYCLES - 1)) ? settle_q : settle_q + 1'b1;
        lat_vld_d = sel_digit && (settle_d == SCW'(SETTLE_CYCLES - 1)) &&
                    (settle_q != SCW'(SETTLE_CYCLES - 1));
    end

    // Digit update: timeout blanks first, a pending latch overrides it.
    always_comb begin
        digits_d = digits_q;
        tmo_d    = tmo_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (tmo_q[d] != TCW'(TIMEOUT_CYCLES))
                tmo_d[d] = tmo_q[d] + 1'b1;
            if (tmo_q[d] == TCW'(TIMEOUT_CYCLES - 1))
                digits_d[d] = '0;
            if (lat_vld_q && (lat_idx_q == 3'(d))) begin
                digits_d[d] = lat_seg_q;
                tmo_d[d]    = '0;
            end
        end
    end

    // Column drive: pull the pressed column low only while its row is scanned.
    always_comb begin
        pai_d = 8'hFF;
        if (press && (sel == {2'b00, code.row}))
            pai_d[code.col] = 1'b0;
    end

    // Scan capture, digit/timeout state, change pulse and port A register.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            scan_q    <= '0;
            settle_q  <= '0;
            lat_vld_q <= 1'b0;
            lat_idx_q <= '0;
            lat_seg_q <= '0;
            digits_q  <= '0;
            tmo_q     <= '0;
            chg_q     <= 1'b0;
            disp_q    <= 1'b0;
            pai_q     <= 8'hFF;
        end else begin
            scan_q    <= {sel, seg};
            settle_q  <= settle_d;
            lat_vld_q <= lat_vld_d;
            lat_idx_q <= sel_idx;
            lat_seg_q <= seg;
            digits_q  <= digits_d;
            tmo_q     <= tmo_d;
            chg_q     <= (digits_d != digits_q);
            disp_q    <= chg_q;
            pai_q     <= pai_d;
        end
    end

    assign digits       = digits_q;
    assign disp_changed = disp_q;
    assign pai          = pai_q;

endmodule

// File: tb/tb_riot_display_keypad.sv
// Bench for riot_display_keypad: cycle model of the display/keypad rules
// compared every cycle, plus directed literal checks.
module tb_riot_display_keypad;

    localparam int S = 4;
    localparam int T = 100;
    localparam int H = 20;
    localparam int R = 20;

    logic        phi2 = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pao = 8'h00, ddra = 8'h00, pbo = 8'h00, ddrb = 8'h00;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic [7:0]  pai;
    logic        key_ready, key_err, disp_changed;
    logic [41:0] digits;

    riot_display_keypad #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .HOLD_CYCLES    (H),
        .RELEASE_CYCLES (R)
    ) dut (
        .phi2         (phi2),
        .rst_n        (rst_n),
        .pao          (pao),
        .ddra         (ddra),
        .pbo          (pbo),
        .ddrb         (ddrb),
        .pai          (pai),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .key_err      (key_err),
        .digits       (digits),
        .disp_changed (disp_changed)
    );

    always #5 phi2 = ~phi2;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  m_dig [6];
    logic [6:0]  m_nd  [6];
    int          m_age [6];
    logic [10:0] m_prev;
    int          m_run;
    logic        m_pend;
    int          m_pd;
    logic [6:0]  m_ps;
    logic        m_chg, m_disp, m_err;
    logic [7:0]  m_pai;
    int          m_left, m_row, m_col;
    logic        m_started = 1'b0;

    function automatic logic [3:0] sel_f(input logic [7:0] p, input logic [7:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = d[i+1] ? p[i+1] : 1'b1;
        return r;
    endfunction

    function automatic logic [41:0] exp_digits();
        logic [41:0] r;
        for (int d = 0; d < 6; d++) r[7*d +: 7] = m_dig[d];
        return r;
    endfunction

    initial begin
        forever begin
            logic [3:0] sv;
            logic [6:0] sg;
            logic       pressed;
            @(posedge phi2);
            sv = sel_f(pbo, ddrb);
            sg = pao[6:0] & ddra[6:0];
            if (!rst_n) begin
                for (int d = 0; d < 6; d++) begin m_dig[d] = 7'd0; m_age[d] = 0; end
                m_prev = 11'd0; m_run = 0; m_pend = 1'b0; m_pd = 0; m_ps = 7'd0;
                m_chg = 1'b0; m_disp = 1'b0; m_err = 1'b0; m_pai = 8'hFF;
                m_left = 0; m_row = 0; m_col = 0;
            end else begin
                // digits: age out, then any pending latch takes priority
                for (int d = 0; d < 6; d++) begin
                    m_nd[d] = m_dig[d];
                    if (m_age[d] < T) begin
                        m_age[d]++;
                        if (m_age[d] == T) m_nd[d] = 7'd0;
                    end
                end
                if (m_pend) begin m_nd[m_pd] = m_ps; m_age[m_pd] = 0; end
                // run length of identical samples; latch on reaching S
                if ({sv, sg} == m_prev) m_run = (m_run < S + 1) ? m_run + 1 : m_run;
                else m_run = 1;
                m_pend = (sv >= 4) && (sv <= 9) && (m_run == S);
                m_pd = int'(sv) - 4;
                m_ps = sg;
                m_disp = m_chg;
                m_chg = 1'b0;
                for (int d = 0; d < 6; d++) begin
                    if (m_nd[d] != m_dig[d]) m_chg = 1'b1;
                    m_dig[d] = m_nd[d];
                end
                // key: m_left counts the remaining hold+release cycles
                pressed = (m_left > R);
                m_pai = (pressed && int'(sv) == m_row) ? ~(8'h01 << m_col) : 8'hFF;
                m_err = 1'b0;
                if (m_left > 0) m_left--;
                else if (key_valid) begin
                    if (key_code[4:3] == 2'd3 || key_code[2:0] == 3'd7) m_err = 1'b1;
                    else begin
                        m_row = int'(key_code[4:3]);
                        m_col = int'(key_code[2:0]);
                        m_left = H + R;
                    end
                end
                m_prev = {sv, sg};
            end
            m_started = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge phi2);
            #1;
            if (m_started) begin
                chk("m_digits", digits, exp_digits());
                chk("m_pai", pai, m_pai);
                chk("m_key_ready", key_ready, (m_left == 0) && rst_n);
                chk("m_key_err", key_err, m_err);
                chk("m_disp_changed", disp_changed, m_disp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge phi2);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        tick(1);
        chk("rst_digits", digits, 42'd0);
        chk("rst_pai", pai, 8'hFF);
        chk("rst_ready", key_ready, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", key_ready, 1'b1);
        ddrb = 8'h1E; ddra = 8'h7F; pbo = 8'h00;
        tick(2);

        // clean scan of digit 0
        pbo = 8'h08; pao = 8'h3F;
        tick(4);
        pbo = 8'h00;
        tick(1);
        chk("scan_d0", digits[6:0], 7'h3F);
        chk("scan_nopulse_yet", disp_changed, 1'b0);
        tick(1);
        chk("scan_pulse", disp_changed, 1'b1);
        tick(1);
        chk("scan_pulse_end", disp_changed, 1'b0);

        // glitch on digit 1: two cycles of 06, then a stable 5B
        pbo = 8'h0A; pao = 8'h06;
        tick(2);
        pao = 8'h5B;
        tick(4);
        pbo = 8'h00;
        chk("glitch_nolatch", digits[13:7], 7'h00);
        tick(1);
        chk("glitch_latch", digits[13:7], 7'h5B);

        // explicit blank on digit 1
        tick(2);
        pbo = 8'h0A; pao = 8'h00;
        tick(4);
        pbo = 8'h00;
        tick(1);
        chk("blank_d1", digits[13:7], 7'h00);

        // digit 5 latches, then ages out after T cycles
        tick(2);
        pbo = 8'h12; pao = 8'h7F;
        tick(4);
        pbo = 8'h00;
        tick(1);
        chk("tmo_latched", digits[41:35], 7'h7F);
        tick(99);
        chk("tmo_before", digits[41:35], 7'h7F);
        tick(1);
        chk("tmo_blank", digits[41:35], 7'h00);
        tick(1);
        chk("tmo_pulse", disp_changed, 1'b1);

        // key row 1 col 3
        tick(2);
        pbo = 8'h02; key_code = 5'b01_011; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        chk("key_busy", key_ready, 1'b0);
        tick(1);
        chk("key_pai_low", pai, 8'hF7);
        pbo = 8'h00;
        tick(1);
        chk("key_pai_other_row", pai, 8'hFF);
        pbo = 8'h02;
        tick(2);
        key_code = 5'b00_000; key_valid = 1'b1;  // ignored while busy
        tick(1);
        key_valid = 1'b0;
        tick(H + R - 6);
        chk("key_still_busy", key_ready, 1'b0);
        tick(1);
        chk("key_ready_again", key_ready, 1'b1);

        // invalid codes: column 7, then row 3
        for (int i = 0; i < 2; i++) begin
            key_code = (i == 0) ? 5'b00_111 : 5'b11_000;
            key_valid = 1'b1;
            tick(1);
            key_valid = 1'b0;
            chk("inv_err", key_err, 1'b1);
            chk("inv_ready", key_ready, 1'b1);
            tick(1);
            chk("inv_err_end", key_err, 1'b0);
        end

        // reset in the middle of a press
        pbo = 8'h00; key_code = 5'b00_010; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        tick(2);
        chk("mid_pai_low", pai, 8'hFB);
        tick(5);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_pai", pai, 8'hFF);
        chk("mid_rst_ready", key_ready, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("mid_after_ready", key_ready, 1'b1);
        chk("mid_after_pai", pai, 8'hFF);
        tick(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
